// File: rtl/pll_clken_pkg.sv
// Shared types and sizing helpers for the PLL-style clock-enable generator.
package pll_clken_pkg;

  typedef enum logic [1:0] {
    SETTLE,
    LOCKED,
    REALIGN
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Settle counter must be able to hold LOCK_CYCLES itself.
  function automatic int lock_cnt_width(input int lock_cycles);
    return (clog2(lock_cycles + 1) < 1) ? 1 : clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/pll_clken_gen_divider.sv
// One divider channel: wrapping counter with strobe and 50%-duty decodes.
module clken_divider #(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             strobe,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W:0]   high_len;

  always_ff @(posedge refclk) begin
    if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt >= div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
    end
  end

  // Odd ratios get the extra cycle in the high half.
  always_comb begin
    high_len = ({1'b0, div} + (DIV_W + 1)'(1)) >> 1;
    strobe   = run && (cnt == phase);
    clk_out  = run && ({1'b0, cnt} < high_len);
  end

endmodule

// File: rtl/pll_clken_gen.sv
// Parametrised clock-enable generator with runtime per-channel divide/phase
// reconfiguration and a PLL-style locked indication.
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int LOCK_CYCLES = 16,
  parameter int CHAN_W      = (NUM_CLOCKS > 1) ? clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int LOCK_W = lock_cnt_width(LOCK_CYCLES);

  state_t             state;
  state_t             state_next;
  logic [LOCK_W-1:0]  settle_cnt;
  logic [DIV_W-1:0]   div_regs   [NUM_CLOCKS];
  logic [DIV_W-1:0]   phase_regs [NUM_CLOCKS];
  logic [CHAN_W-1:0]  shadow_chan;
  logic [DIV_W-1:0]   shadow_div;
  logic [DIV_W-1:0]   shadow_phase;
  logic [DIV_W-1:0]   san_div;
  logic [DIV_W-1:0]   san_phase;
  logic               handshake;
  logic               chan_ok;
  logic               realign;
  logic               run;
  logic               clear;

  // rst gates the handshake combinationally so it always wins over a config write.
  always_comb begin
    state_next = state;
    cfg_ready  = (state == LOCKED) && !rst;
    locked     = (state == LOCKED) && !rst;
    handshake  = cfg_valid && cfg_ready;
    chan_ok    = 32'(cfg_chan) < 32'(NUM_CLOCKS);
    realign    = (state == REALIGN);
    run        = !rst && !realign;
    clear      = rst || realign;
    case (state)
      SETTLE:  if (settle_cnt == LOCK_W'(LOCK_CYCLES - 1)) state_next = LOCKED;
      LOCKED:  if (handshake && chan_ok) state_next = REALIGN;
      REALIGN: state_next = SETTLE;
      default: state_next = SETTLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= SETTLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst || state != SETTLE) begin
      settle_cnt <= '0;
    end else begin
      settle_cnt <= settle_cnt + LOCK_W'(1);
    end
  end

  always_comb begin
    san_div   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    san_phase = (cfg_phase >= san_div) ? san_div - DIV_W'(1) : cfg_phase;
  end

  always_ff @(posedge refclk) begin
    if (handshake && chan_ok) begin
      shadow_chan  <= cfg_chan;
      shadow_div   <= san_div;
      shadow_phase <= san_phase;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        div_regs[i]   <= DIV_W'(DEFAULT_DIV);
        phase_regs[i] <= '0;
      end
    end else if (realign) begin
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        if (shadow_chan == CHAN_W'(i)) begin
          div_regs[i]   <= shadow_div;
          phase_regs[i] <= shadow_phase;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    clken_divider #(
      .DIV_W(DIV_W)
    ) u_divider (
      .refclk (refclk),
      .clear  (clear),
      .run    (run),
      .div    (div_regs[g]),
      .phase  (phase_regs[g]),
      .strobe (outclk_en[g]),
      .clk_out(outclk[g])
    );
  end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Scoreboarded bench for pll_clken_gen driven from a table of stimulus segments.
module tb_pll_clken_gen;

  localparam int NC  = 2;
  localparam int DW  = 8;
  localparam int DEF = 4;
  localparam int LC  = 16;
  localparam int CW  = 2;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_phase;
  logic [NC-1:0] outclk_en;
  logic [NC-1:0] outclk;
  logic          locked;

  always #5 refclk = ~refclk;

  pll_clken_gen #(
    .NUM_CLOCKS (NC),
    .DIV_W      (DW),
    .DEFAULT_DIV(DEF),
    .LOCK_CYCLES(LC),
    .CHAN_W     (CW)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .outclk_en(outclk_en),
    .outclk   (outclk),
    .locked   (locked)
  );

  typedef struct {
    logic [NC-1:0] en;
    logic [NC-1:0] clk;
    logic          lk;
    logic          rdy;
  } exp_t;

  typedef struct {
    logic r;
    logic v;
    int   ch;
    int   d;
    int   ph;
    int   cycles;
    logic exp_lk;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[0:17];
  int   errors = 0;
  int   checks = 0;

  // Reference model: n counts running cycles since the last restart.
  int m_realign = 0;
  int n = 0;
  int mdiv[NC];
  int mph[NC];
  int p_ch, p_d, p_ph;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input int ch, input int d,
                       input int ph, output logic acc);
    exp_t e;
    int   rem;
    @(negedge refclk);
    rst       = r;
    cfg_valid = v;
    cfg_chan  = CW'(ch);
    cfg_div   = DW'(d);
    cfg_phase = DW'(ph);
    acc   = 1'b0;
    e.en  = '0;
    e.clk = '0;
    e.lk  = 1'b0;
    e.rdy = 1'b0;
    if (r) begin
      for (int i = 0; i < NC; i++) begin
        mdiv[i] = DEF;
        mph[i]  = 0;
      end
      n = 0;
      m_realign = 0;
    end else if (m_realign != 0) begin
      mdiv[p_ch] = p_d;
      mph[p_ch]  = p_ph;
      n = 0;
      m_realign = 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        rem = n % mdiv[i];
        e.en[i]  = (rem == mph[i]);
        e.clk[i] = (rem < (mdiv[i] + 1) / 2);
      end
      e.lk  = (n >= LC);
      e.rdy = e.lk;
      acc   = v && e.rdy;
      if (acc && ch < NC) begin
        p_ch = ch;
        p_d  = (d == 0) ? 1 : d;
        p_ph = (ph >= p_d) ? p_d - 1 : ph;
        m_realign = 1;
      end else begin
        n++;
      end
    end
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("outclk_en", 32'(outclk_en), 32'(e.en));
    chk("outclk", 32'(outclk), 32'(e.clk));
    chk("locked", 32'(locked), 32'(e.lk));
    chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
  endtask

  task automatic run_vec(input vec_t t);
    logic hold;
    logic acc;
    hold = t.v;
    for (int c = 0; c < t.cycles; c++) begin
      cycle(t.r, hold, t.ch, t.d, t.ph, acc);
      if (acc) hold = 1'b0;
    end
    chk("locked_at_segment_end", 32'(locked), 32'(t.exp_lk));
  endtask

  initial begin
    logic acc;
    int   waited;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    for (int i = 0; i < NC; i++) begin
      mdiv[i] = DEF;
      mph[i]  = 0;
    end

    //          r     v     ch d  ph cyc lock
    tbl[0]  = '{1'b1, 1'b0, 0, 0, 0,  3, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 0, 0, 0, 40, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1, 5, 2, 30, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 0, 0, 7, 25, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 0, 3, 9, 25, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 3, 7, 1, 10, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 0, 0, 0,  1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 0, 0, 0,  5, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 0, 0, 0,  2, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 0, 0, 0, 10, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1, 2, 1, 40, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 0, 0, 0, 20, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1, 9, 0,  1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 0, 0, 0, 20, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1, 6, 0,  1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 0, 0, 0,  1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 0, 0, 0, 24, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1, 1, 5, 22, 1'b1};

    for (int k = 0; k <= 10; k++) run_vec(tbl[k]);

    // Request held from reset release: ready stays low for exactly LC cycles.
    cycle(1'b1, 1'b0, 0, 0, 0, acc);
    waited = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b1, 0, 7, 3, acc);
      if (cfg_ready === 1'b1) break;
      waited++;
    end
    chk("ready_wait_after_reset", 32'(waited), 32'(LC));

    for (int k = 11; k <= 17; k++) run_vec(tbl[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_clken_gen.md
Name: pll_clken_gen

Overview:
- Parametrised, pure-RTL successor to the fixed two-output PLL wrapper.
- Generates NUM_CLOCKS clock-enable strobes and divided 50%-duty clock signals from refclk.
- Divide ratio and phase are runtime-reconfigurable per channel through a valid/ready config port.
- Provides a PLL-style locked output: locked drops on reconfiguration and reasserts after a settle period with all channels phase-realigned.
- Used by NIOS-side peripherals that need slower synchronous rates without consuming a PLL resource.

Parameters:
- NUM_CLOCKS, 2, number of output channels (1..16).
- DIV_W, 8, width of the divide and phase fields.
- DEFAULT_DIV, 4, divide ratio loaded into every channel at reset (1..2^DIV_W-1).
- LOCK_CYCLES, 16, settle cycles before locked asserts (>=1).
- CHAN_W, max(1,clog2(NUM_CLOCKS)), width of the channel index.

Ports:
- refclk, input, 1, sole clock; all logic on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- cfg_valid, input, 1, config request valid.
- cfg_ready, output, 1, config accepted when valid&ready.
- cfg_chan, input, CHAN_W, target channel.
- cfg_div, input, DIV_W, new divide ratio.
- cfg_phase, input, DIV_W, new strobe phase offset in refclk cycles.
- outclk_en, output, NUM_CLOCKS, one-cycle enable strobe per channel.
- outclk, output, NUM_CLOCKS, divided clock-shaped signal per channel (data use only, never a clock net).
- locked, output, 1, all channels running and aligned.

Behaviour:
- Reset (rst=1), checked every cycle:
  - Outputs: outclk_en=0, outclk=0, locked=0, cfg_ready=0.
  - All div regs=DEFAULT_DIV, phase regs=0, counters=0, state=SETTLE, settle counter=0.
  - rst has priority over any simultaneous cfg handshake. rst mid-reconfig aborts it; the channel keeps DEFAULT_DIV.
- FSM states:
  - SETTLE: counters run; settle counter increments each cycle. Transition to LOCKED when the counter reaches LOCK_CYCLES-1.
  - LOCKED: locked=1, cfg_ready=1. On handshake go to REALIGN.
  - REALIGN: one cycle. Load the shadow config into the addressed channel; clear all channel counters and the settle counter; outclk_en=0, outclk=0. Transition to SETTLE.
- cfg_ready is 0 outside LOCKED. The master holds cfg_valid and its fields stable until the handshake.
- Timing: locked=0 the cycle after an accepted handshake. Cycle n=0 is the first cycle after rst release, or the first cycle after REALIGN. locked rises at cycle n=LOCK_CYCLES.
- Per-channel counter:
  - cnt counts 0..div-1 and wraps to 0. Wrap is at div-1; counting is not free-running modulo 2^DIV_W.
  - outclk_en[i]=1 in cycles where cnt==phase.
  - outclk[i]=1 where cnt < (div+1)>>1. Odd divides are high-biased by one cycle.
  - Both outputs are combinational decodes of registered state. They are forced 0 during reset and REALIGN.
- Sanitising at capture:
  - cfg_div=0 is coerced to 1.
  - cfg_phase >= div is clamped to div-1.
  - div=1: outclk_en=1 and outclk=1 every running cycle.
- cfg_chan >= NUM_CLOCKS:
  - Handshake completes; no channel is updated.
  - No REALIGN occurs; locked stays 1.
- All channels share one counter restart, so channels with related ratios keep a deterministic phase relationship after every lock.

Decomposition:
- Package pll_clken_pkg:
  - state enum {SETTLE, LOCKED, REALIGN};
  - clog2 helper function;
  - localparam for the locked-counter width, clog2(LOCK_CYCLES+1).
- Sub-module clken_divider, one instance per channel:
  - inputs: refclk, clear, run, div, phase;
  - outputs: strobe, clk_out.
  - The top holds the FSM, config capture/sanitise and settle counter.

Test Plan:
- Reset release with defaults (NUM_CLOCKS=2, DEFAULT_DIV=4, LOCK_CYCLES=16):
  - outclk_en[0] and outclk_en[1] high at n=0,4,8,...
  - outclk high at n mod 4 in {0,1};
  - locked=0 for n<16 and 1 from n=16.
- In LOCKED, write chan=1 div=5 phase=2:
  - cfg_ready=1 during the handshake; locked=0 next cycle; both outputs 0 in the REALIGN cycle.
  - Afterwards outclk_en[1] high at n=2,7,12,...; outclk[1] high at n mod 5 in {0,1,2}; outclk_en[0] back at n=0,4,...
  - locked high at n=16.
- Sanitising:
  - write chan=0 div=0 phase=7 -> div=1, outclk_en[0] and outclk[0] constant 1 after REALIGN.
  - write div=3 phase=9 -> strobe at n mod 3 ==2.
- cfg_valid held during SETTLE: cfg_ready=0 until locked rises; the handshake completes on the first LOCKED cycle.
- cfg_chan=3 with NUM_CLOCKS=2 -> handshake completes, locked stays 1, output patterns unchanged.
- rst asserted in the same cycle as a handshake, and asserted mid-SETTLE -> all outputs 0 the next cycle; DEFAULT_DIV pattern resumes from n=0 after release.
